// File: rtl/trinity_ddr_pkg.sv
// rtl/trinity_ddr_pkg.sv - Shared types and constants for the DDR responder.
package trinity_ddr_pkg;

  localparam int LINE_W         = 512;
  localparam int WORD_W         = 64;
  localparam int WORDS_PER_LINE = LINE_W / WORD_W;

  // 16-bit Fibonacci LFSR, taps 16,14,13,11 (bit positions 15,13,12,10)
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/ddr_resp_mem.sv
// rtl/ddr_resp_mem.sv - Single-port line memory with bitwise-masked line write.
// Contents are deliberately not reset.
module ddr_resp_mem
  import trinity_ddr_pkg::*;
#(
  parameter int LINE_AW = 10
) (
  input  logic               clock,
  input  logic               wr_en,
  input  logic [LINE_AW-1:0] addr,
  input  logic [LINE_W-1:0]  wr_mask,
  input  logic [LINE_W-1:0]  wr_data,
  output logic [LINE_W-1:0]  rd_data
);

  logic [LINE_W-1:0] mem_q [2**LINE_AW];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[addr] <= (mem_q[addr] & ~wr_mask) | (wr_data & wr_mask);
    end
  end

  assign rd_data = mem_q[addr];

endmodule

// File: rtl/ddr_responder.sv
// rtl/ddr_responder.sv - Fixed-latency DDR line/word memory responder, one request at a time.
// Build option DDR_RESP_RAND_LAT_EN: adds 0..7 LFSR-chosen extra busy cycles per request.
module ddr_responder
  import trinity_ddr_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int LINE_AW = 10
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ddr_chip_enable,
  input  logic [63:0]       ddr_index,
  input  logic              ddr_write_enable,
  input  logic              ddr_burst_mode,
  input  logic [LINE_W-1:0] ddr_write_mask,
  input  logic [LINE_W-1:0] ddr_write_data,
  output logic [LINE_W-1:0] ddr_read_data,
  output logic              ddr_operation_done,
  output logic              ddr_ready
);

  state_e             state_q, state_d;
  logic [4:0]         count_q, count_d;
  logic [4:0]         target_q, target_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;
  logic [LINE_W-1:0]  rdata_q, rdata_d;
  logic               we_q, we_d;
  logic               burst_q, burst_d;
  logic [LINE_AW-1:0] line_q, line_d;
  logic [2:0]         word_q, word_d;
  logic [LINE_W-1:0]  mask_q, mask_d;
  logic [LINE_W-1:0]  data_q, data_d;

  logic               accept;
  logic [2:0]         extra;
  logic               mem_we;
  logic [LINE_W-1:0]  mem_mask, mem_data, mem_rdata;

  // Offset bits and bits above the line field never affect addressing.
  logic unused_idx;
  assign unused_idx = ^{ddr_index[63:6+LINE_AW], ddr_index[2:0]};

  assign accept = ddr_chip_enable && ready_q;

`ifdef DDR_RESP_RAND_LAT_EN
  logic [15:0] lfsr_q, lfsr_d;

  assign extra = lfsr_q[2:0];

  always_comb begin
    lfsr_d = lfsr_q;
    if (accept) lfsr_d = lfsr_next(lfsr_q);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) lfsr_q <= LFSR_SEED;
    else          lfsr_q <= lfsr_d;
  end
`else
  assign extra = 3'd0;
`endif

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    target_d = target_q;
    we_d     = we_q;
    burst_d  = burst_q;
    line_d   = line_q;
    word_d   = word_q;
    mask_d   = mask_q;
    data_d   = data_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          we_d     = ddr_write_enable;
          burst_d  = ddr_burst_mode;
          line_d   = ddr_index[6+LINE_AW-1:6];
          word_d   = ddr_index[5:3];
          mask_d   = ddr_write_mask;
          data_d   = ddr_write_data;
          target_d = 5'(LATENCY - 1) + {2'b00, extra};
          // count is 1 in the first busy cycle, so busy lasts target cycles
          if (target_d == 5'd0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_BUSY;
            count_d = 5'd1;
          end
        end
      end
      ST_BUSY: begin
        if (count_q == target_q) state_d = ST_DONE;
        else                     count_d = count_q + 5'd1;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        count_d = 5'd0;
      end
      default: begin
        state_d = ST_IDLE;
        count_d = 5'd0;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  // Read data is loaded on the edge entering DONE so it is valid in the done cycle.
  always_comb begin
    rdata_d = rdata_q;
    if (state_d == ST_DONE && state_q != ST_DONE && !we_d) begin
      if (burst_d) rdata_d = mem_rdata;
      else         rdata_d = LINE_W'(mem_rdata[{word_d, 6'b0} +: WORD_W]);
    end
  end

  always_comb begin
    mem_we = (state_q == ST_DONE) && we_q;
    if (burst_q) begin
      mem_mask = mask_q;
      mem_data = data_q;
    end else begin
      mem_mask = LINE_W'(mask_q[WORD_W-1:0]) << {word_q, 6'b0};
      mem_data = LINE_W'(data_q[WORD_W-1:0]) << {word_q, 6'b0};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      count_q  <= 5'd0;
      target_q <= 5'd0;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
      rdata_q  <= '0;
      we_q     <= 1'b0;
      burst_q  <= 1'b0;
      line_q   <= '0;
      word_q   <= 3'd0;
      mask_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      target_q <= target_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
      we_q     <= we_d;
      burst_q  <= burst_d;
      line_q   <= line_d;
      word_q   <= word_d;
      mask_q   <= mask_d;
      data_q   <= data_d;
    end
  end

  ddr_resp_mem #(
    .LINE_AW (LINE_AW)
  ) u_mem (
    .clock   (clock),
    .wr_en   (mem_we),
    .addr    (line_d),
    .wr_mask (mem_mask),
    .wr_data (mem_data),
    .rd_data (mem_rdata)
  );

  assign ddr_read_data      = rdata_q;
  assign ddr_operation_done = done_q;
  assign ddr_ready          = ready_q;

endmodule
